// File: rtl/sbox_bank_if.sv
// Lookup stream and table-programming port of sbox_bank.
// The master drives lookups and table writes; the slave is the S-box bank.
interface sbox_bank_if #(
  parameter int LANES = 8,
  parameter int IN_W  = 6,
  parameter int OUT_W = 2,
  parameter int LW    = (LANES > 1) ? $clog2(LANES) : 1
);
  logic                   in_valid;
  logic                   in_ready;
  logic [LANES*IN_W-1:0]  in_data;
  logic                   out_valid;
  logic                   out_ready;
  logic [LANES*OUT_W-1:0] out_data;
  logic                   cfg_we;
  logic [LW-1:0]          cfg_lane;
  logic [IN_W-1:0]        cfg_addr;
  logic [OUT_W-1:0]       cfg_data;

  modport master (
    output in_valid, in_data, out_ready, cfg_we, cfg_lane, cfg_addr, cfg_data,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready, cfg_we, cfg_lane, cfg_addr, cfg_data,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/sbox_bank.sv
// Bank of LANES runtime-programmable S-box tables behind a 2-stage valid/ready
// pipeline: stage 1 registers the addresses, stage 2 registers the lookup result.
module sbox_bank #(
  parameter int LANES = 8,
  parameter int IN_W  = 6,
  parameter int OUT_W = 2,
  localparam int LW   = (LANES > 1) ? $clog2(LANES) : 1
) (
  input logic        clk,
  input logic        rst,
  sbox_bank_if.slave bus
);
  localparam int DEPTH = 1 << IN_W;

  logic                   s1_v;
  logic [LANES*IN_W-1:0]  s1_d;
  logic                   out_valid_q;
  logic [LANES*OUT_W-1:0] out_data_q;
  logic [LANES*OUT_W-1:0] lookup;
  logic                   advance;
  logic                   accept;

  // Table writes win over lookups, so a write cycle never accepts a vector.
  assign advance       = !out_valid_q || bus.out_ready;
  assign bus.in_ready  = advance && !bus.cfg_we && !rst;
  assign accept        = bus.in_valid && bus.in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;

  // One table per lane; a cfg_lane beyond the last lane matches none of them.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [OUT_W-1:0] mem [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        mem <= '{default: '0};
      end else if (bus.cfg_we && (bus.cfg_lane == LW'(l))) begin
        mem[bus.cfg_addr] <= bus.cfg_data;
      end
    end

    assign lookup[l*OUT_W +: OUT_W] = mem[s1_d[l*IN_W +: IN_W]];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v        <= 1'b0;
      s1_d        <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else if (advance) begin
      out_valid_q <= s1_v;
      out_data_q  <= lookup;
      s1_v        <= accept;
      if (accept) begin
        s1_d <= bus.in_data;
      end
    end
  end
endmodule

// File: tb/tb_sbox_bank.sv
// Randomized bench for sbox_bank: an 8-lane bank checked against array/queue
// tables, plus a 6-lane bank for writes aimed past the last lane.
module tb_sbox_bank;
  localparam int L   = 8;
  localparam int IW  = 6;
  localparam int OW  = 2;
  localparam int DW  = L * IW;
  localparam int QW  = L * OW;
  localparam int L6  = 6;
  localparam int QW6 = L6 * OW;

  logic clk = 1'b0;
  logic rst;
  int   vectors = 0;
  int   miscompares = 0;

  logic [OW-1:0] model_tbl [L][64];
  logic [OW-1:0] model6    [L6][64];
  logic [QW-1:0] exp_q [$];

  always #5 clk = ~clk;

  sbox_bank_if #(.LANES(L),  .IN_W(IW), .OUT_W(OW)) bus  ();
  sbox_bank_if #(.LANES(L6), .IN_W(IW), .OUT_W(OW)) bus6 ();

  sbox_bank #(.LANES(L),  .IN_W(IW), .OUT_W(OW)) dut  (.clk(clk), .rst(rst), .bus(bus));
  sbox_bank #(.LANES(L6), .IN_W(IW), .OUT_W(OW)) dut6 (.clk(clk), .rst(rst), .bus(bus6));

  function automatic logic [QW-1:0] model_lookup(input logic [DW-1:0] d);
    logic [QW-1:0] r;
    r = '0;
    for (int i = 0; i < L; i++) r[i*OW +: OW] = model_tbl[i][d[i*IW +: IW]];
    return r;
  endfunction

  // Expected results are computed when a vector is accepted; no test writes a
  // table while an older vector could still be waiting for its lookup.
  task automatic drive_cycle(input logic v, input logic [DW-1:0] d, input logic ordy,
                             input logic we, input logic [2:0] lane, input logic [IW-1:0] addr,
                             input logic [OW-1:0] cd, output logic ov, output logic [QW-1:0] od,
                             output logic rdy);
    logic acc;
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.out_ready = ordy;
    bus.cfg_we    = we;
    bus.cfg_lane  = lane;
    bus.cfg_addr  = addr;
    bus.cfg_data  = cd;
    #4;
    ov  = bus.out_valid;
    od  = bus.out_data;
    rdy = bus.in_ready;
    acc = v && rdy;
    @(posedge clk);
    if (acc) exp_q.push_back(model_lookup(d));
    if (we) model_tbl[lane][addr] = cd;
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic ov, rdy;
    logic [QW-1:0] od, exp;
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== '0 || bus.in_ready !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_por: got valid=%b data=%h ready=%b, required 0/0/0",
               bus.out_valid, bus.out_data, bus.in_ready);
    end
    rst = 1'b0;
    for (int c = 0; c < 4; c++)
      drive_cycle(1'b1, DW'({$urandom(), $urandom()}), 1'b1, 1'b0, 3'd0, '0, '0, ov, od, rdy);
    rst = 1'b1;
    #1;
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== '0 || bus.in_ready !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_mid: got valid=%b data=%h ready=%b, required 0/0/0",
               bus.out_valid, bus.out_data, bus.in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    for (int i = 0; i < L; i++) for (int a = 0; a < 64; a++) model_tbl[i][a] = '0;
    // One vector after release: result must appear two cycles after it is presented.
    for (int c = 0; c < 5; c++) begin
      drive_cycle(c == 0, DW'({$urandom(), $urandom()}), 1'b1, 1'b0, 3'd0, '0, '0, ov, od, rdy);
      if (c == 0) begin
        vectors++;
        if (rdy !== 1'b1) begin
          miscompares++;
          $display("[TB] FAIL reset_release_ready: got %b, required 1", rdy);
        end
      end
      vectors++;
      if (ov !== (c == 2)) begin
        miscompares++;
        $display("[TB] FAIL reset_latency c=%0d: got valid=%b, required %b", c, ov, c == 2);
      end
      if (ov && exp_q.size() > 0) begin
        exp = exp_q.pop_front();
        vectors++;
        if (od !== exp || od !== '0) begin
          miscompares++;
          $display("[TB] FAIL reset_zero_data: got %h, required %h", od, QW'(0));
        end
      end
    end
  endtask

  task automatic test_program();
    logic ov, rdy;
    logic [QW-1:0] od;
    logic [DW-1:0] d;
    drive_cycle(1'b0, '0, 1'b1, 1'b1, 3'd2, 6'h15, 2'b11, ov, od, rdy);
    d = '0;
    d[2*IW +: IW] = 6'h15;
    for (int c = 0; c < 4; c++) begin
      drive_cycle(c == 0, d, 1'b1, 1'b0, 3'd0, '0, '0, ov, od, rdy);
      vectors++;
      if (ov !== (c == 2) || (c == 2 && od !== 16'h0030)) begin
        miscompares++;
        $display("[TB] FAIL program_lane2 c=%0d: got valid=%b data=%h, required valid=%b data=0030",
                 c, ov, od, c == 2);
      end
      if (ov && exp_q.size() > 0) void'(exp_q.pop_front());
    end
  endtask

  task automatic test_streaming();
    logic ov, rdy;
    logic [QW-1:0] od, exp;
    for (int i = 0; i < L; i++)
      for (int a = 0; a < 64; a++)
        drive_cycle(1'b0, '0, 1'b1, 1'b1, 3'(i), 6'(a), 2'((a ^ i) & 3), ov, od, rdy);
    for (int c = 0; c < 104; c++) begin
      drive_cycle(c < 100, DW'({$urandom(), $urandom()}), 1'b1, 1'b0, 3'd0, '0, '0, ov, od, rdy);
      if (c < 100) begin
        vectors++;
        if (rdy !== 1'b1) begin
          miscompares++;
          $display("[TB] FAIL stream_ready c=%0d: got %b, required 1", c, rdy);
        end
      end
      vectors++;
      if (ov !== (c >= 2 && c < 102)) begin
        miscompares++;
        $display("[TB] FAIL stream_rate c=%0d: got valid=%b, required %b", c, ov, c >= 2 && c < 102);
      end
      if (ov) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("[TB] FAIL stream_extra: got output %h, required none", od);
        end else begin
          exp = exp_q.pop_front();
          if (od !== exp) begin
            miscompares++;
            $display("[TB] FAIL stream_data c=%0d: got %h, required %h", c, od, exp);
          end
        end
      end
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL stream_lost: got %0d undelivered, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_config_stream();
    logic ov, rdy;
    logic [QW-1:0] od, exp;
    logic [DW-1:0] d;
    for (int c = 0; c < 24; c++) begin
      d = DW'({$urandom(), $urandom()});
      if (c >= 8) d[IW-1:0] = '0;
      drive_cycle(c < 20, d, 1'b1, c == 10, 3'd0, 6'h00, 2'b01, ov, od, rdy);
      if (c == 10) begin
        vectors++;
        if (rdy !== 1'b0) begin
          miscompares++;
          $display("[TB] FAIL cfg_ready: got %b, required 0", rdy);
        end
      end
      vectors++;
      if (ov !== (c >= 2 && c <= 21 && c != 12)) begin
        miscompares++;
        $display("[TB] FAIL cfg_bubble c=%0d: got valid=%b, required %b", c, ov,
                 c >= 2 && c <= 21 && c != 12);
      end
      if (ov) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("[TB] FAIL cfg_extra: got output %h, required none", od);
        end else begin
          exp = exp_q.pop_front();
          if (od !== exp) begin
            miscompares++;
            $display("[TB] FAIL cfg_data c=%0d: got %h, required %h", c, od, exp);
          end
        end
      end
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL cfg_lost: got %0d undelivered, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_backpressure();
    logic ov, rdy, ordy, v, prev_stall;
    logic [QW-1:0] od, exp, prev_od;
    int stall_accepts;
    prev_stall = 1'b0;
    prev_od = '0;
    stall_accepts = 0;
    for (int c = 0; c < 40; c++) begin
      v    = (c < 26) || (c >= 28 && c < 31);
      ordy = !((c >= 10 && c < 15) || (c >= 28 && c < 34));
      drive_cycle(v, DW'({$urandom(), $urandom()}), ordy, 1'b0, 3'd0, '0, '0, ov, od, rdy);
      vectors++;
      if (rdy !== (!ov || ordy)) begin
        miscompares++;
        $display("[TB] FAIL bp_ready c=%0d: got %b, required %b", c, rdy, !ov || ordy);
      end
      if (prev_stall) begin
        vectors++;
        if (ov !== 1'b1 || od !== prev_od) begin
          miscompares++;
          $display("[TB] FAIL bp_hold c=%0d: got valid=%b data=%h, required 1/%h", c, ov, od, prev_od);
        end
      end
      if (c >= 28 && c < 31 && v && rdy) stall_accepts++;
      if (ov && ordy) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("[TB] FAIL bp_extra: got output %h, required none", od);
        end else begin
          exp = exp_q.pop_front();
          if (od !== exp) begin
            miscompares++;
            $display("[TB] FAIL bp_data c=%0d: got %h, required %h", c, od, exp);
          end
        end
      end
      prev_stall = ov && !ordy;
      prev_od    = od;
    end
    vectors++;
    if (stall_accepts != 2) begin
      miscompares++;
      $display("[TB] FAIL bp_absorb: got %0d accepts into a stalled empty pipe, required 2", stall_accepts);
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL bp_lost: got %0d undelivered, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_out_of_range();
    logic [QW6-1:0] exp;
    bus6.out_ready = 1'b1;
    bus6.in_valid  = 1'b0;
    for (int i = 0; i < L6; i++) begin
      for (int a = 0; a < 64; a++) begin
        model6[i][a]  = 2'($urandom_range(0, 3));
        bus6.cfg_we   = 1'b1;
        bus6.cfg_lane = 3'(i);
        bus6.cfg_addr = 6'(a);
        bus6.cfg_data = model6[i][a];
        @(negedge clk);
      end
    end
    // Lanes 6 and 7 do not exist; these writes must leave every table untouched.
    for (int k = 0; k < 16; k++) begin
      bus6.cfg_we   = 1'b1;
      bus6.cfg_lane = 3'(6 + (k & 1));
      bus6.cfg_addr = 6'($urandom_range(0, 63));
      bus6.cfg_data = 2'($urandom_range(0, 3));
      @(negedge clk);
    end
    bus6.cfg_we = 1'b0;
    for (int c = 0; c < 66; c++) begin
      bus6.in_valid = (c < 64);
      for (int i = 0; i < L6; i++) bus6.in_data[i*IW +: IW] = 6'(c);
      #4;
      if (c >= 2) begin
        for (int i = 0; i < L6; i++) exp[i*OW +: OW] = model6[i][c-2];
        vectors++;
        if (bus6.out_valid !== 1'b1 || bus6.out_data !== exp) begin
          miscompares++;
          $display("[TB] FAIL oor_readback addr=%0d: got valid=%b data=%h, required 1/%h",
                   c - 2, bus6.out_valid, bus6.out_data, exp);
        end
      end
      @(posedge clk);
      @(negedge clk);
    end
    bus6.in_valid = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got no completion, required finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    rst = 1'b1;
    bus.in_valid   = 1'b0;
    bus.in_data    = '0;
    bus.out_ready  = 1'b1;
    bus.cfg_we     = 1'b0;
    bus.cfg_lane   = '0;
    bus.cfg_addr   = '0;
    bus.cfg_data   = '0;
    bus6.in_valid  = 1'b0;
    bus6.in_data   = '0;
    bus6.out_ready = 1'b1;
    bus6.cfg_we    = 1'b0;
    bus6.cfg_lane  = '0;
    bus6.cfg_addr  = '0;
    bus6.cfg_data  = '0;
    @(negedge clk);
    @(negedge clk);
    test_reset();
    test_program();
    test_streaming();
    test_config_stream();
    test_backpressure();
    test_out_of_range();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
